// File: rtl/cumsum_exclusive_inverse_pkg.sv
// Shared definitions for the exclusive cumulative-sum inverse block.
//   state_t            : row-framing FSM states
//   ERR_FIRST_NZ       : err bit set when the first beat of a row is nonzero
//   ERR_LAST_MISALIGN  : err bit set when in_last does not mark beat ROW_LEN
//   DEFAULT_DATA_W     : default element/sum width
package cumsum_exclusive_inverse_pkg;

  typedef enum logic {
    S_FIRST = 1'b0,  // expecting y[0] of a new row
    S_BODY  = 1'b1   // expecting y[1..ROW_LEN]
  } state_t;

  localparam int ERR_FIRST_NZ      = 0;
  localparam int ERR_LAST_MISALIGN = 1;
  localparam int DEFAULT_DATA_W    = 32;

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register carrying data plus a last flag.
//   clk, rst     : clock, asynchronous active-high reset
//   load_i       : write data_i/last_i into the register this cycle
//   data_i       : data to load
//   last_i       : last flag to load
//   can_load_o   : register is empty or being drained this cycle
//   out_valid_o  : register holds a beat
//   out_data_o   : held data, stable while out_valid_o && !out_ready_i
//   out_last_o   : held last flag
//   out_ready_i  : downstream accepts the held beat
// Handshake: a beat moves on any rising edge where valid and ready are both
// high; the producer never drops valid or changes data until that happens.
// The caller only asserts load_i when can_load_o is high, so a drain and a
// reload in the same cycle give one beat per cycle.
module stream_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  output logic         can_load_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         out_last_o,
  input  logic         out_ready_i
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         last_q;

  assign can_load_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/cumsum_exclusive_inverse.sv
// Rebuilds x[i] = y[i+1] - y[i] from a row of exclusive prefix sums
// y[0..ROW_LEN-1] followed by the row total y[ROW_LEN].
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : input beat valid
//   in_ready   : block can accept an input beat
//   in_data    : exclusive prefix sum, or row total on the final beat
//   in_last    : marks the row-total beat
//   out_valid  : reconstructed element valid
//   out_ready  : downstream accepts the element
//   out_data   : reconstructed element (mod 2^DATA_W)
//   out_last   : last element of the row
//   err        : sticky error flags, cleared only by rst
// Handshake: a beat transfers on a rising edge with valid && ready high;
// valid never depends combinationally on ready, and in_ready only depends on
// state and out_ready.
module cumsum_exclusive_inverse
  import cumsum_exclusive_inverse_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int ROW_LEN = 8,
  parameter int CNT_W   = $clog2(ROW_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [1:0]        err
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [1:0]        err_q, err_d;

  logic              accept;
  logic              can_load;
  logic              load;
  logic              load_last;
  logic              row_full;
  logic [DATA_W-1:0] diff;

  // S_FIRST never loads the output register, so it can always take a beat.
  assign in_ready = (state_q == S_FIRST) || can_load;
  assign accept   = in_valid && in_ready;
  assign row_full = (cnt_q == CNT_W'(ROW_LEN));
  assign diff     = in_data - prev_q;
  assign err      = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    err_d     = err_q;
    load      = 1'b0;
    load_last = 1'b0;
    if (accept) begin
      case (state_q)
        S_FIRST: begin
          if (in_last) begin
            // A total with no row before it is dropped.
            err_d[ERR_LAST_MISALIGN] = 1'b1;
          end else begin
            prev_d  = in_data;
            cnt_d   = CNT_W'(1);
            state_d = S_BODY;
            // A nonzero base is flagged but still used as the reference.
            if (in_data != '0) err_d[ERR_FIRST_NZ] = 1'b1;
          end
        end
        S_BODY: begin
          load   = 1'b1;
          prev_d = in_data;
          cnt_d  = cnt_q + CNT_W'(1);
          // Either an early in_last or the ROW_LEN-th body beat closes the
          // row; disagreement between the two is a framing error.
          if (in_last || row_full) begin
            load_last = 1'b1;
            state_d   = S_FIRST;
            cnt_d     = '0;
            if (in_last != row_full) err_d[ERR_LAST_MISALIGN] = 1'b1;
          end
        end
        default: state_d = S_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FIRST;
      cnt_q   <= '0;
      prev_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      err_q   <= err_d;
    end
  end

  stream_out_reg #(
    .W (DATA_W)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .data_i      (diff),
    .last_i      (load_last),
    .can_load_o  (can_load),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_ready_i (out_ready)
  );

endmodule

// File: tb/tb_cumsum_exclusive_inverse.sv
module tb_cumsum_exclusive_inverse;

  localparam int DATA_W  = 32;
  localparam int ROW_LEN = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [1:0]        err;

  int checks = 0;
  int errors = 0;

  // Expected output beats: {last, data}
  logic [DATA_W:0] exp_q[$];

  cumsum_exclusive_inverse #(
    .DATA_W  (DATA_W),
    .ROW_LEN (ROW_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Inputs change 1 time unit after posedge, so a valid&&ready seen at the
  // negedge is the transfer taken on the following posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [DATA_W:0] e;
      checks++;
      assert (exp_q.size() != 0)
      else begin
        errors++;
        $error("FAIL out_unexpected got=%0b_%08h exp=none", out_last, out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({out_last, out_data} === e)
        else begin
          errors++;
          $error("FAIL out_beat got=%0b_%08h exp=%0b_%08h",
                 out_last, out_data, e[DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input logic [DATA_W-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  // Called 1 unit after a posedge; returns 1 unit after the accepting edge.
  task automatic send(input logic [DATA_W-1:0] d, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $error("FAIL send_timeout got=in_ready0 exp=in_ready1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
    chk("rst_err",       64'(err),       64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    do_reset();

    // Basic round trip: 0,3,4,8,9 -> 3,1,4,1(last)
    expect_out(32'd3, 1'b0);
    expect_out(32'd1, 1'b0);
    expect_out(32'd4, 1'b0);
    expect_out(32'd1, 1'b1);
    send(32'd0, 1'b0);
    send(32'd3, 1'b0);
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("latency_data",  64'(out_data),  64'd3);
    send(32'd4, 1'b0);
    send(32'd8, 1'b0);
    send(32'd9, 1'b1);
    drain("basic_drain");

    // Backpressure: hold the first output for 3 cycles
    expect_out(32'd3, 1'b0);
    expect_out(32'd1, 1'b0);
    expect_out(32'd4, 1'b0);
    expect_out(32'd1, 1'b1);
    out_ready = 1'b0;
    send(32'd0, 1'b0);
    send(32'd3, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd4;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data",  64'(out_data),  64'd3);
      chk("bp_in_ready",   64'(in_ready),  64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'd4, 1'b0);
    send(32'd8, 1'b0);
    send(32'd9, 1'b1);
    drain("bp_drain");

    // Wrap / negative: 0,FFFFFFFF,2,3,7 -> FFFFFFFF,3,1,4(last)
    expect_out(32'hFFFF_FFFF, 1'b0);
    expect_out(32'h0000_0003, 1'b0);
    expect_out(32'h0000_0001, 1'b0);
    expect_out(32'h0000_0004, 1'b1);
    send(32'h0000_0000, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0002, 1'b0);
    send(32'h0000_0003, 1'b0);
    send(32'h0000_0007, 1'b1);
    drain("wrap_drain");
    chk("err_clean", 64'(err), 64'd0);

    // Nonzero first beat: 5,8,9,10,11 -> 3,1,1,1(last), err[0]
    expect_out(32'd3, 1'b0);
    expect_out(32'd1, 1'b0);
    expect_out(32'd1, 1'b0);
    expect_out(32'd1, 1'b1);
    send(32'd5,  1'b0);
    send(32'd8,  1'b0);
    send(32'd9,  1'b0);
    send(32'd10, 1'b0);
    send(32'd11, 1'b1);
    drain("nz_drain");
    chk("nz_err", 64'(err), 64'h1);

    // Early last: 0,2,5,7(last) -> 2,3,2(last), err[1]; then a clean row
    expect_out(32'd2, 1'b0);
    expect_out(32'd3, 1'b0);
    expect_out(32'd2, 1'b1);
    send(32'd0, 1'b0);
    send(32'd2, 1'b0);
    send(32'd5, 1'b0);
    send(32'd7, 1'b1);
    drain("early_drain");
    chk("early_err", 64'(err), 64'h3);
    for (int i = 0; i < 4; i++) expect_out(32'd1, (i == 3));
    for (int i = 0; i <= 4; i++) send(32'(i), (i == 4));
    drain("reframe_drain");

    // Reset mid-row with an output pending
    send(32'd0, 1'b0);
    send(32'd1, 1'b0);
    expect_out(32'd1, 1'b0);
    send(32'd2, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_err",   64'(err),       64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) expect_out(32'd2, (i == 3));
    for (int i = 0; i <= 4; i++) send(32'(2 * i), (i == 4));
    drain("post_rst_drain");
    chk("post_rst_err", 64'(err), 64'd0);

    // Missing last: total beat without in_last still closes the row
    for (int i = 0; i < 4; i++) expect_out(32'd1, (i == 3));
    for (int i = 0; i <= 4; i++) send(32'(i), 1'b0);
    drain("miss_drain");
    chk("miss_err", 64'(err), 64'h2);
    for (int i = 0; i < 4; i++) expect_out(32'd3, (i == 3));
    for (int i = 0; i <= 4; i++) send(32'(3 * i), (i == 4));
    drain("miss_next_drain");

    // in_last on the first beat is dropped without output
    do_reset();
    send(32'd9, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("first_last_err",   64'(err),       64'h2);
    chk("first_last_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 4; i++) expect_out(32'd5, (i == 3));
    for (int i = 0; i <= 4; i++) send(32'(5 * i), (i == 4));
    drain("first_last_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
